// File: rtl/mem_access_lsu_if.sv
// Signal bundle between the LSU, the MEM stage and the SRAM-like data bus.
// The LSU owns the bus side, so it takes the master view; the environment takes the slave view.
interface mem_access_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [5:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              flush;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_adel;
    logic              resp_ades;
    logic [ADDR_W-1:0] resp_bad_addr;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, flush,
        input  data_addr_ok, data_data_ok, data_rdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_adel, resp_ades, resp_bad_addr,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, flush,
        output data_addr_ok, data_data_ok, data_rdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_adel, resp_ades, resp_bad_addr,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata
    );
endinterface

// File: rtl/mem_access_lsu.sv
// In-order load/store unit: alignment check, strobes, up to DEPTH outstanding bus accesses, 0-latency responses.
// Optional MEM_KSEG_MAP_EN maps kseg0/kseg1 virtual addresses (0x8/0xB top nibble) to physical.
module mem_access_lsu #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_lsu_if.master bus
);
    localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25, OP_SB  = 6'h28, OP_SH = 6'h29, OP_SW  = 6'h2b;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [5:0]        op;
        logic [1:0]        lo;
        logic              exc;
        logic              killed;
        logic [ADDR_W-1:0] vaddr;
    } entry_t;

    typedef enum logic {IDLE, REQ} state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t            state, state_nxt;
    entry_t            q [DEPTH];
    entry_t            head;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              req_ld, req_st, req_exc;
    logic [1:0]        req_sz;
    logic [3:0]        req_strb;
    logic [31:0]       req_wd;
    logic [ADDR_W-1:0] req_pa;
    logic              accept, issue_new, retire;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       fmt;

    always_comb begin
        req_ld = is_load(bus.req_op);
        req_st = is_store(bus.req_op);
        case (bus.req_op)
            OP_LB, OP_LBU, OP_SB: req_sz = 2'd0;
            OP_LH, OP_LHU, OP_SH: req_sz = 2'd1;
            default:              req_sz = 2'd2;
        endcase
        req_exc = (req_ld || req_st) &&
                  ((req_sz == 2'd1 && bus.req_addr[0]) || (req_sz == 2'd2 && bus.req_addr[1:0] != 2'b00));
        case (req_sz)
            2'd0: begin
                req_strb = 4'b0001 << bus.req_addr[1:0];
                req_wd   = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                req_strb = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                req_wd   = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                req_strb = 4'b1111;
                req_wd   = bus.req_wdata;
            end
        endcase
        if (!req_st) req_strb = 4'b0000;
    end

`ifdef MEM_KSEG_MAP_EN
    logic [ADDR_W+31:0] pa_ext;
    always_comb begin
        pa_ext = {32'b0, bus.req_addr};
        if (pa_ext[31:28] == 4'hB)      pa_ext[31:28] = 4'h1;
        else if (pa_ext[31:28] == 4'h8) pa_ext[31:28] = 4'h0;
        req_pa = pa_ext[ADDR_W-1:0];
    end
`else
    assign req_pa = bus.req_addr;
`endif

    assign accept    = bus.req_valid && bus.req_ready;
    assign issue_new = accept && !req_exc;
    assign head      = q[rd_ptr];
    // Exception heads retire on their own; data_data_ok only ever belongs to an issued head.
    assign retire    = (count != '0) && (head.exc || bus.data_data_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue_new) state_nxt = REQ;
            REQ:     if (issue_new) state_nxt = REQ;
                     else if (bus.data_addr_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.data_req  = (state == REQ);
        bus.req_ready = !bus.flush && (count < CW'(DEPTH)) && (state == IDLE || bus.data_addr_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data_wr    <= 1'b0;
            bus.data_size  <= 2'd0;
            bus.data_addr  <= '0;
            bus.data_wstrb <= 4'b0000;
            bus.data_wdata <= 32'b0;
        end else if (issue_new) begin
            bus.data_wr    <= req_st;
            bus.data_size  <= req_sz;
            bus.data_addr  <= req_pa;
            bus.data_wstrb <= req_strb;
            bus.data_wdata <= req_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (bus.flush) begin
                for (int i = 0; i < DEPTH; i++) q[i].killed <= 1'b1;
            end
            if (accept) begin
                q[wr_ptr] <= '{op: bus.req_op, lo: bus.req_addr[1:0], exc: req_exc,
                               killed: 1'b0, vaddr: bus.req_addr};
                wr_ptr    <= ptr_inc(wr_ptr);
            end
            if (retire) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(accept) - CW'(retire);
        end
    end

    always_comb begin
        case (head.lo)
            2'd0:    lane_b = bus.data_rdata[7:0];
            2'd1:    lane_b = bus.data_rdata[15:8];
            2'd2:    lane_b = bus.data_rdata[23:16];
            default: lane_b = bus.data_rdata[31:24];
        endcase
        lane_h = head.lo[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        case (head.op)
            OP_LB:   fmt = {{24{lane_b[7]}}, lane_b};
            OP_LBU:  fmt = {24'b0, lane_b};
            OP_LH:   fmt = {{16{lane_h[15]}}, lane_h};
            OP_LHU:  fmt = {16'b0, lane_h};
            OP_LW:   fmt = bus.data_rdata;
            default: fmt = 32'b0;
        endcase
        bus.resp_valid    = retire && !head.killed;
        bus.resp_rdata    = (bus.resp_valid && !head.exc) ? fmt : 32'b0;
        bus.resp_adel     = bus.resp_valid && head.exc && is_load(head.op);
        bus.resp_ades     = bus.resp_valid && head.exc && is_store(head.op);
        bus.resp_bad_addr = (bus.resp_valid && head.exc) ? head.vaddr : '0;
    end
endmodule

// File: tb/tb_mem_access_lsu.sv
// Table-driven bench for mem_access_lsu with an in-order response scoreboard and hand-written corner sequences.
module tb_mem_access_lsu;
    localparam logic [5:0] OP_LB  = 6'h20, OP_LH  = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25, OP_SB  = 6'h28, OP_SH = 6'h29, OP_SW  = 6'h2b;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, wdata, rdata;
        logic [1:0]  size;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] bwd, erd;
        logic        adel, ades;
    } vec_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        adel, ades;
        logic [31:0] bad;
    } resp_t;

    logic clk, rst;
    mem_access_lsu_if #(.ADDR_W(32)) ifc();
    mem_access_lsu #(.ADDR_W(32), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(ifc));

    int    n_cmp = 0, n_err = 0, issued = 0;
    resp_t sb[$];
    vec_t  vt[15];
    logic        s_req_ready, s_data_req, s_wr, s_resp_valid;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(logic [5:0] op, logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                logic [1:0] size, logic wr, logic [3:0] wstrb, logic [31:0] bwd,
                                logic [31:0] erd, logic adel, logic ades);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.size = size; v.wr = wr;
        v.wstrb = wstrb; v.bwd = bwd; v.erd = erd; v.adel = adel; v.ades = ades;
        return v;
    endfunction

    function automatic logic [31:0] phys_of(logic [31:0] va);
`ifdef MEM_KSEG_MAP_EN
        if (va[31:28] == 4'hB) return {4'h1, va[27:0]};
        if (va[31:28] == 4'h8) return {4'h0, va[27:0]};
`endif
        return va;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // One clock: sample everything at the falling edge, then return just after the next rising edge.
    task automatic cyc();
        resp_t e;
        @(negedge clk);
        s_req_ready = ifc.req_ready;  s_data_req = ifc.data_req;  s_wr = ifc.data_wr;
        s_size = ifc.data_size;       s_addr = ifc.data_addr;     s_wstrb = ifc.data_wstrb;
        s_wdata = ifc.data_wdata;     s_resp_valid = ifc.resp_valid;
        if (ifc.resp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_resp_valid", 32'(ifc.resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", ifc.resp_rdata, e.rdata);
                check("resp_adel", 32'(ifc.resp_adel), 32'(e.adel));
                check("resp_ades", 32'(ifc.resp_ades), 32'(e.ades));
                check("resp_bad_addr", ifc.resp_bad_addr, e.bad);
            end
        end
        if (ifc.data_data_ok) begin
            assert (issued > 0) else $error("data_data_ok driven with nothing outstanding");
            if (issued > 0) issued--;
        end
        if (ifc.data_req && ifc.data_addr_ok) issued++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input resp_t exp);
        bit ok = 0;
        ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_addr = addr; ifc.req_wdata = wdata;
        for (int i = 0; i < 20 && !ok; i++) begin
            cyc();
            if (s_req_ready) begin
                ok = 1;
                sb.push_back(exp);
            end
        end
        ifc.req_valid = 1'b0;
        check("req_accepted", 32'(ok), 32'd1);
    endtask

    initial begin
        vec_t  v;
        resp_t er;
        int    acc;

        vt[0]  = mk(OP_LW,  32'h8000_0010, 0, 32'h1234_5678, 2, 0, 4'b0000, 0, 32'h1234_5678, 0, 0);
        vt[1]  = mk(OP_LH,  32'h1000_0002, 0, 32'h8001_0000, 1, 0, 4'b0000, 0, 32'hFFFF_8001, 0, 0);
        vt[2]  = mk(OP_LBU, 32'h1000_0003, 0, 32'hAB00_0000, 0, 0, 4'b0000, 0, 32'h0000_00AB, 0, 0);
        vt[3]  = mk(OP_LB,  32'h1000_0001, 0, 32'h0000_8000, 0, 0, 4'b0000, 0, 32'hFFFF_FF80, 0, 0);
        vt[4]  = mk(OP_LHU, 32'h1000_0000, 0, 32'h1234_8765, 1, 0, 4'b0000, 0, 32'h0000_8765, 0, 0);
        vt[5]  = mk(OP_SH,  32'h1000_0002, 32'h0000_BEEF, 32'hFFFF_FFFF, 1, 1, 4'b1100, 32'hBEEF_BEEF, 0, 0, 0);
        vt[6]  = mk(OP_SB,  32'h1000_0003, 32'h0000_005A, 32'h1111_1111, 0, 1, 4'b1000, 32'h5A5A_5A5A, 0, 0, 0);
        vt[7]  = mk(OP_SW,  32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 2, 1, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0);
        vt[8]  = mk(OP_LW,  32'hBFC0_0000, 0, 32'hCAFE_F00D, 2, 0, 4'b0000, 0, 32'hCAFE_F00D, 0, 0);
        vt[9]  = mk(OP_LB,  32'h1000_0003, 0, 32'h7F00_0000, 0, 0, 4'b0000, 0, 32'h0000_007F, 0, 0);
        vt[10] = mk(OP_LW,  32'h1000_0001, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[11] = mk(OP_SH,  32'h1000_0001, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[12] = mk(OP_SW,  32'h1000_0006, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1);
        vt[13] = mk(OP_LH,  32'h1000_0003, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        vt[14] = mk(OP_SB,  32'h1000_0002, 32'h0000_00C3, 32'h0, 0, 1, 4'b0100, 32'hC3C3_C3C3, 0, 0, 0);

        rst = 1'b1;
        ifc.req_valid = 0; ifc.req_op = 0; ifc.req_addr = 0; ifc.req_wdata = 0; ifc.flush = 0;
        ifc.data_addr_ok = 0; ifc.data_data_ok = 0; ifc.data_rdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_req", 32'(ifc.data_req), 0);
        check("rst_data_wr", 32'(ifc.data_wr), 0);
        check("rst_data_size", 32'(ifc.data_size), 0);
        check("rst_data_addr", ifc.data_addr, 0);
        check("rst_data_wstrb", 32'(ifc.data_wstrb), 0);
        check("rst_data_wdata", ifc.data_wdata, 0);
        check("rst_resp_valid", 32'(ifc.resp_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();
        check("post_rst_req_ready", 32'(s_req_ready), 1);

        foreach (vt[k]) begin
            v = vt[k];
            er.rdata = v.erd; er.adel = v.adel; er.ades = v.ades;
            er.bad = (v.adel || v.ades) ? v.addr : 32'h0;
            send(v.op, v.addr, v.wdata, er);
            if (!(v.adel || v.ades)) begin
                ifc.data_addr_ok = 1'b1;
                cyc();
                ifc.data_addr_ok = 1'b0;
                check($sformatf("v%0d_data_req", k), 32'(s_data_req), 1);
                check($sformatf("v%0d_data_wr", k), 32'(s_wr), 32'(v.wr));
                check($sformatf("v%0d_data_size", k), 32'(s_size), 32'(v.size));
                check($sformatf("v%0d_data_addr", k), s_addr, phys_of(v.addr));
                check($sformatf("v%0d_data_wstrb", k), 32'(s_wstrb), 32'(v.wstrb));
                if (v.wr) check($sformatf("v%0d_data_wdata", k), s_wdata, v.bwd);
                cyc();
                ifc.data_data_ok = 1'b1; ifc.data_rdata = v.rdata;
                cyc();
                ifc.data_data_ok = 1'b0;
            end else begin
                cyc();
                check($sformatf("v%0d_no_bus_req", k), 32'(s_data_req), 0);
            end
            check($sformatf("v%0d_all_resp_seen", k), 32'(sb.size()), 0);
        end

        // An exception must wait behind an older load that is still waiting for its data.
        er = '{rdata: 32'h1111_2222, adel: 1'b0, ades: 1'b0, bad: 32'h0};
        send(OP_LW, 32'h1000_0020, 0, er);
        ifc.data_addr_ok = 1'b1;
        cyc();
        ifc.data_addr_ok = 1'b0;
        er = '{rdata: 32'h0, adel: 1'b1, ades: 1'b0, bad: 32'h1000_0021};
        send(OP_LW, 32'h1000_0021, 0, er);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("order_no_second_req", 32'(s_data_req), 0);
            check("order_exc_held", 32'(s_resp_valid), 0);
        end
        ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'h1111_2222;
        cyc();
        check("order_first_resp", 32'(s_resp_valid), 1);
        ifc.data_data_ok = 1'b0;
        cyc();
        check("order_exc_resp", 32'(s_resp_valid), 1);
        check("order_drained", 32'(sb.size()), 0);

        // Fill the queue with data withheld, then flush: outstanding data_ok must be swallowed.
        acc = 0;
        ifc.req_valid = 1'b1; ifc.req_op = OP_LW; ifc.req_addr = 32'h1000_0040; ifc.data_addr_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (s_req_ready) acc++;
        end
        check("full_accepted", 32'(acc), 2);
        check("full_req_ready", 32'(s_req_ready), 0);
        check("full_issued", 32'(issued), 2);
        ifc.req_valid = 1'b0; ifc.data_addr_ok = 1'b0; ifc.flush = 1'b1;
        cyc();
        check("flush_req_ready", 32'(s_req_ready), 0);
        ifc.flush = 1'b0; ifc.data_data_ok = 1'b1; ifc.data_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("flush_killed_resp", 32'(s_resp_valid), 0);
        end
        ifc.data_data_ok = 1'b0;
        cyc();
        check("flush_queue_free", 32'(s_req_ready), 1);

        // Asynchronous reset while a request is sitting on the bus.
        er = '{rdata: 32'h0, adel: 1'b0, ades: 1'b0, bad: 32'h0};
        send(OP_SW, 32'h1000_0080, 32'hFEED_FACE, er);
        check("mid_req_data_req", 32'(ifc.data_req), 1);
        rst = 1'b1;
        #1;
        check("async_rst_data_req", 32'(ifc.data_req), 0);
        check("async_rst_data_addr", ifc.data_addr, 0);
        check("async_rst_data_wstrb", 32'(ifc.data_wstrb), 0);
        sb.delete();
        issued = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc();
        check("after_rst_req_ready", 32'(s_req_ready), 1);
        check("after_rst_data_req", 32'(s_data_req), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
